music_seq_ctrl: RTL and testbench

MUSIC_SEQ_CTRL -- requirements
Module: music_seq_ctrl

---
 rtl/music_seq_ctrl.sv | 142 ++++++++++++++
 tb/tb_music_seq_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/music_seq_ctrl.sv
// Beat sequencer for the music player: divides the system clock down to beat
// rate, steps a beat index through the selected song, and handles start, stop,
// pause, looping and end-of-song. All outputs come straight from flops.
module music_seq_ctrl #(
   parameter logic [31:0] CLK_FREQ  = 32'd100_000_000,
   parameter logic [31:0] BEAT_FREQ = 32'd8,
   parameter logic [8:0]  LEN0      = 9'd128,
   parameter logic [8:0]  LEN1      = 9'd128,
   parameter logic [8:0]  LEN2      = 9'd128,
   parameter logic [8:0]  LEN3      = 9'd128
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   input  logic [1:0] song_sel,
   input  logic       loop_en,
   output logic [7:0] ibeat,
   output logic [1:0] song,
   output logic       beat_tick,
   output logic       playing,
   output logic       done
);

   localparam logic [31:0] DIV      = CLK_FREQ / BEAT_FREQ;
   localparam logic [31:0] DIV_LAST = DIV - 32'd1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2,
      END   = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] div_cnt;
   logic [31:0] div_nxt;
   logic [7:0]  ibeat_nxt;
   logic [1:0]  song_nxt;
   logic        tick_nxt;
   logic        done_nxt;
   logic        playing_nxt;
   logic        last_beat;

   // Song length in beats for a given song index (1..256, hence 9 bits).
   function automatic logic [8:0] song_len(input logic [1:0] idx);
      logic [8:0] len;
      case (idx)
         2'd0:    len = LEN0;
         2'd1:    len = LEN1;
         2'd2:    len = LEN2;
         default: len = LEN3;
      endcase
      return len;
   endfunction

   // Final beat of the latched song; 9-bit compare so LEN=256 ends at 255.
   assign last_beat = ({1'b0, ibeat} == (song_len(song) - 9'd1));

   // Next-state and next-output logic; stop beats start, start beats pause.
   always_comb begin
      state_nxt = state;
      div_nxt   = div_cnt;
      ibeat_nxt = ibeat;
      song_nxt  = song;
      tick_nxt  = 1'b0;
      done_nxt  = 1'b0;
      if (stop) begin
         state_nxt = IDLE;
         div_nxt   = 32'd0;
         ibeat_nxt = 8'd0;
      end else if (start) begin
         state_nxt = PLAY;
         song_nxt  = song_sel;
         div_nxt   = 32'd0;
         ibeat_nxt = 8'd0;
      end else begin
         case (state)
            PLAY: begin
               // The divider runs on every PLAY cycle, including the one that
               // enters PAUSE, so a beat always spans exactly DIV PLAY cycles.
               if (pause) begin
                  state_nxt = PAUSE;
               end
               if (div_cnt == DIV_LAST) begin
                  div_nxt  = 32'd0;
                  tick_nxt = 1'b1;
                  if (!last_beat) begin
                     ibeat_nxt = ibeat + 8'd1;
                  end else if (loop_en) begin
                     ibeat_nxt = 8'd0;
                  end else begin
                     state_nxt = END;
                     done_nxt  = 1'b1;
                  end
               end else begin
                  div_nxt = div_cnt + 32'd1;
               end
            end
            PAUSE: begin
               if (!pause) begin
                  state_nxt = PLAY;
               end
            end
            default: begin
            end
         endcase
      end
      playing_nxt = (state_nxt == PLAY) || (state_nxt == PAUSE);
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Divider, beat index, latched song and registered status pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt   <= 32'd0;
         ibeat     <= 8'd0;
         song      <= 2'd0;
         beat_tick <= 1'b0;
         playing   <= 1'b0;
         done      <= 1'b0;
      end else begin
         div_cnt   <= div_nxt;
         ibeat     <= ibeat_nxt;
         song      <= song_nxt;
         beat_tick <= tick_nxt;
         playing   <= playing_nxt;
         done      <= done_nxt;
      end
   end

endmodule

// File: tb/tb_music_seq_ctrl.sv
// Directed self-checking bench for music_seq_ctrl with DIV=5 and short songs.
module tb_music_seq_ctrl;

   logic       clk;
   logic       reset;
   logic       start;
   logic       stop;
   logic       pause;
   logic [1:0] song_sel;
   logic       loop_en;
   logic [7:0] ibeat;
   logic [1:0] song;
   logic       beat_tick;
   logic       playing;
   logic       done;

   int n_cmp = 0;
   int n_bad = 0;

   music_seq_ctrl #(
      .CLK_FREQ (32'd40),
      .BEAT_FREQ(32'd8),
      .LEN0     (9'd1),
      .LEN1     (9'd3),
      .LEN2     (9'd256),
      .LEN3     (9'd4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .stop     (stop),
      .pause    (pause),
      .song_sel (song_sel),
      .loop_en  (loop_en),
      .ibeat    (ibeat),
      .song     (song),
      .beat_tick(beat_tick),
      .playing  (playing),
      .done     (done)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Advance until beat_tick is seen; n = cycles taken, -1 if none in budget.
   task automatic wait_tick(input int max_cyc, output int n, output bit saw_done);
      n = -1;
      saw_done = 1'b0;
      for (int k = 1; k <= max_cyc; k++) begin
         step();
         if (done === 1'b1) saw_done = 1'b1;
         if (beat_tick === 1'b1) begin
            n = k;
            break;
         end
      end
   endtask

   task automatic do_start(input logic [1:0] sel, input logic lp);
      start = 1'b1;
      song_sel = sel;
      loop_en = lp;
      step();
      start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1;
      step();
      stop = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      pause = 1'b0;
      song_sel = 2'd0;
      loop_en = 1'b0;
      #1 reset = 1'b0;
      #2;
      n_cmp++; if (ibeat !== 8'd0) begin n_bad++; $display("FAIL rst_ibeat: got %0d want 0", ibeat); end
      n_cmp++; if (song !== 2'd0) begin n_bad++; $display("FAIL rst_song: got %0d want 0", song); end
      n_cmp++; if (beat_tick !== 1'b0) begin n_bad++; $display("FAIL rst_tick: got %b want 0", beat_tick); end
      n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL rst_playing: got %b want 0", playing); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
      step();
      step();
      reset = 1'b1;
      step();
      step();
      n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL idle_playing: got %b want 0", playing); end
   endtask

   task automatic test_single();
      int n;
      bit sd;
      do_start(2'd1, 1'b0);
      n_cmp++; if (playing !== 1'b1) begin n_bad++; $display("FAIL s1_playing: got %b want 1", playing); end
      n_cmp++; if (ibeat !== 8'd0) begin n_bad++; $display("FAIL s1_ibeat0: got %0d want 0", ibeat); end
      n_cmp++; if (song !== 2'd1) begin n_bad++; $display("FAIL s1_song: got %0d want 1", song); end
      for (int t = 1; t <= 3; t++) begin
         wait_tick(20, n, sd);
         n_cmp++; if (n != 5) begin n_bad++; $display("FAIL s1_period%0d: got %0d want 5", t, n); end
         n_cmp++; if (ibeat !== ((t == 3) ? 8'd2 : t[7:0])) begin n_bad++; $display("FAIL s1_ibeat%0d: got %0d", t, ibeat); end
         n_cmp++; if (sd !== (t == 3)) begin n_bad++; $display("FAIL s1_done%0d: got %b want %b", t, sd, (t == 3)); end
      end
      n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL s1_end_playing: got %b want 0", playing); end
      step();
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL s1_done_pulse: got %b want 0", done); end
      wait_tick(15, n, sd);
      n_cmp++; if (n != -1) begin n_bad++; $display("FAIL s1_end_hold_tick: got %0d want -1", n); end
      n_cmp++; if (ibeat !== 8'd2) begin n_bad++; $display("FAIL s1_end_ibeat: got %0d want 2", ibeat); end
      do_start(2'd1, 1'b0);
      n_cmp++; if (playing !== 1'b1 || ibeat !== 8'd0) begin n_bad++; $display("FAIL s1_restart: got playing=%b ibeat=%0d want 1/0", playing, ibeat); end
      do_stop();
   endtask

   task automatic test_loop();
      int n;
      bit sd;
      bit any_done;
      logic [7:0] exp_b [0:4];
      exp_b[0] = 8'd1; exp_b[1] = 8'd2; exp_b[2] = 8'd0; exp_b[3] = 8'd1; exp_b[4] = 8'd2;
      any_done = 1'b0;
      do_start(2'd1, 1'b1);
      for (int t = 0; t < 5; t++) begin
         wait_tick(20, n, sd);
         if (sd) any_done = 1'b1;
         n_cmp++; if (n != 5 || ibeat !== exp_b[t]) begin n_bad++; $display("FAIL s2_tick%0d: got n=%0d ibeat=%0d want 5/%0d", t, n, ibeat, exp_b[t]); end
      end
      n_cmp++; if (any_done !== 1'b0) begin n_bad++; $display("FAIL s2_done: got %b want 0", any_done); end
      n_cmp++; if (playing !== 1'b1) begin n_bad++; $display("FAIL s2_playing: got %b want 1", playing); end
      do_stop();
   endtask

   task automatic test_pause();
      int n;
      bit sd;
      bit any_tick;
      bit lost_play;
      any_tick = 1'b0;
      lost_play = 1'b0;
      do_start(2'd1, 1'b0);
      wait_tick(20, n, sd);
      step();
      step();
      pause = 1'b1;
      for (int k = 0; k < 12; k++) begin
         step();
         if (beat_tick !== 1'b0) any_tick = 1'b1;
         if (playing !== 1'b1) lost_play = 1'b1;
      end
      n_cmp++; if (any_tick !== 1'b0) begin n_bad++; $display("FAIL s3_tick_in_pause: got %b want 0", any_tick); end
      n_cmp++; if (lost_play !== 1'b0) begin n_bad++; $display("FAIL s3_playing_in_pause: got %b want 0", lost_play); end
      n_cmp++; if (ibeat !== 8'd1) begin n_bad++; $display("FAIL s3_ibeat_held: got %0d want 1", ibeat); end
      pause = 1'b0;
      wait_tick(20, n, sd);
      n_cmp++; if (n != 3) begin n_bad++; $display("FAIL s3_resume_latency: got %0d want 3", n); end
      n_cmp++; if (ibeat !== 8'd2) begin n_bad++; $display("FAIL s3_ibeat_after: got %0d want 2", ibeat); end
      do_stop();
   endtask

   task automatic test_start_stop();
      int n;
      bit sd;
      do_start(2'd1, 1'b0);
      wait_tick(20, n, sd);
      step();
      start = 1'b1;
      stop = 1'b1;
      step();
      start = 1'b0;
      stop = 1'b0;
      n_cmp++; if (ibeat !== 8'd0) begin n_bad++; $display("FAIL s4_ibeat: got %0d want 0", ibeat); end
      n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL s4_playing: got %b want 0", playing); end
      wait_tick(15, n, sd);
      n_cmp++; if (n != -1) begin n_bad++; $display("FAIL s4_idle_tick: got %0d want -1", n); end
   endtask

   task automatic test_async_reset();
      int n;
      bit sd;
      do_start(2'd1, 1'b0);
      wait_tick(20, n, sd);
      wait_tick(20, n, sd);
      step();
      step();
      n_cmp++; if (ibeat !== 8'd2 || song !== 2'd1) begin n_bad++; $display("FAIL s5_pre: got ibeat=%0d song=%0d want 2/1", ibeat, song); end
      #2 reset = 1'b0;
      #1;
      n_cmp++; if (ibeat !== 8'd0) begin n_bad++; $display("FAIL s5_ibeat: got %0d want 0", ibeat); end
      n_cmp++; if (song !== 2'd0) begin n_bad++; $display("FAIL s5_song: got %0d want 0", song); end
      n_cmp++; if (playing !== 1'b0 || beat_tick !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL s5_flags: got playing=%b tick=%b done=%b want 0", playing, beat_tick, done); end
      step();
      reset = 1'b1;
      wait_tick(15, n, sd);
      n_cmp++; if (n != -1) begin n_bad++; $display("FAIL s5_no_tick: got %0d want -1", n); end
      n_cmp++; if (playing !== 1'b0) begin n_bad++; $display("FAIL s5_playing_after: got %b want 0", playing); end
   endtask

   task automatic test_song_latch();
      int n;
      bit sd;
      do_start(2'd1, 1'b0);
      song_sel = 2'd3;
      wait_tick(20, n, sd);
      n_cmp++; if (song !== 2'd1) begin n_bad++; $display("FAIL s6_song_held: got %0d want 1", song); end
      do_start(2'd3, 1'b0);
      n_cmp++; if (song !== 2'd3 || ibeat !== 8'd0) begin n_bad++; $display("FAIL s6_relatch: got song=%0d ibeat=%0d want 3/0", song, ibeat); end
      do_stop();
   endtask

   task automatic test_len_one();
      int n;
      bit sd;
      do_start(2'd0, 1'b0);
      wait_tick(20, n, sd);
      n_cmp++; if (n != 5 || sd !== 1'b1) begin n_bad++; $display("FAIL len1_end: got n=%0d done=%b want 5/1", n, sd); end
      n_cmp++; if (ibeat !== 8'd0 || playing !== 1'b0) begin n_bad++; $display("FAIL len1_state: got ibeat=%0d playing=%b want 0/0", ibeat, playing); end
      do_start(2'd0, 1'b1);
      wait_tick(20, n, sd);
      wait_tick(20, n, sd);
      n_cmp++; if (n != 5 || sd !== 1'b0 || ibeat !== 8'd0 || playing !== 1'b1) begin n_bad++; $display("FAIL len1_loop: got n=%0d done=%b ibeat=%0d playing=%b want 5/0/0/1", n, sd, ibeat, playing); end
      do_stop();
   endtask

   task automatic test_len_256();
      int n;
      bit sd;
      bit bad_period;
      bad_period = 1'b0;
      do_start(2'd2, 1'b1);
      for (int t = 0; t < 255; t++) begin
         wait_tick(20, n, sd);
         if (n != 5) bad_period = 1'b1;
      end
      n_cmp++; if (bad_period !== 1'b0) begin n_bad++; $display("FAIL len256_period: got %b want 0", bad_period); end
      n_cmp++; if (ibeat !== 8'd255) begin n_bad++; $display("FAIL len256_top: got %0d want 255", ibeat); end
      wait_tick(20, n, sd);
      n_cmp++; if (ibeat !== 8'd0 || sd !== 1'b0 || playing !== 1'b1) begin n_bad++; $display("FAIL len256_wrap: got ibeat=%0d done=%b playing=%b want 0/0/1", ibeat, sd, playing); end
      do_stop();
   endtask

   task automatic test_loop_live();
      int n;
      bit sd;
      do_start(2'd3, 1'b1);
      for (int t = 0; t < 3; t++) wait_tick(20, n, sd);
      n_cmp++; if (ibeat !== 8'd3) begin n_bad++; $display("FAIL live_last: got %0d want 3", ibeat); end
      loop_en = 1'b0;
      wait_tick(20, n, sd);
      n_cmp++; if (sd !== 1'b1 || ibeat !== 8'd3 || playing !== 1'b0) begin n_bad++; $display("FAIL live_end: got done=%b ibeat=%0d playing=%b want 1/3/0", sd, ibeat, playing); end
      do_stop();
   endtask

   initial begin
      test_reset();
      test_single();
      test_loop();
      test_pause();
      test_start_stop();
      test_async_reset();
      test_song_latch();
      test_len_one();
      test_len_256();
      test_loop_live();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
